// File: rtl/bnn_layer_scheduler_pkg.sv
// bnn_sched_pkg: shared state encoding, default parameters and saturating increment for the BNN layer scheduler
package bnn_sched_pkg;
  typedef enum logic [2:0] {IDLE, RUN, LATCH, CLEAR, DONE, ERROR} sched_state_t;
  localparam int DEF_CLEAR_CYCLES = 1;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return v >= max ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/bnn_layer_scheduler_if.sv
// bnn_layer_scheduler_if: command/status and per-layer go/done/latch bundle.
//   slave  : scheduler side (inputs start, abort, result_ack, layer_done;
//            outputs layer_go, layer_latch, cur_layer, busy, done, error, cycle_count)
//   master : controller/layer side, directions mirrored
interface bnn_layer_scheduler_if #(parameter int NUM_LAYERS = 2, parameter int CNT_W = 16);
  logic start, abort, result_ack, busy, done, error;
  logic [NUM_LAYERS-1:0] layer_done, layer_go, layer_latch;
  logic [$clog2(NUM_LAYERS):0] cur_layer;
  logic [CNT_W-1:0] cycle_count;
  modport slave(input start, abort, result_ack, layer_done,
                output layer_go, layer_latch, cur_layer, busy, done, error, cycle_count);
  modport master(output start, abort, result_ack, layer_done,
                 input layer_go, layer_latch, cur_layer, busy, done, error, cycle_count);
endinterface

// File: rtl/bnn_layer_scheduler_watchdog.sv
// bnn_sched_watchdog: per-layer RUN-cycle counter flagging a layer that exceeds its time budget.
//   clk, rst : clock, async active-high reset
//   clr      : zero the counter (held while not in RUN, so it restarts on RUN entry)
//   en       : count this cycle (in RUN)
//   expired  : this is the TIMEOUT_CYCLES-th counted cycle without completion
module bnn_sched_watchdog import bnn_sched_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : en ? TW'(sat_inc(32'(cnt), 32'(TIMEOUT_CYCLES))) : cnt;
  assign expired = en && cnt >= TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/bnn_layer_scheduler.sv
// bnn_layer_scheduler: sequences a chain of BNN layers (go -> done -> latch -> clear) and profiles inference cycles.
//   clk, rst : clock, async active-high reset
//   bus      : bnn_layer_scheduler_if.slave (start/abort/result_ack, layer_done in;
//              layer_go/layer_latch/cur_layer/busy/done/error/cycle_count out, all registered)
//   Optional macro BNN_SCHED_WATCHDOG_EN adds a per-layer timeout that ends in ERROR.
module bnn_layer_scheduler import bnn_sched_pkg::*; #(
  parameter int NUM_LAYERS     = 2,
  parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
  input logic clk,
  input logic rst,
  bnn_layer_scheduler_if.slave bus
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  sched_state_t state;
  logic [CW-1:0] clr_cnt;
  logic timeout, cur_done;
  // Only the active layer's done is looked at; stray bits of other layers are masked off.
  assign cur_done = |(bus.layer_done & (NUM_LAYERS'(1) << bus.cur_layer));
`ifdef BNN_SCHED_WATCHDOG_EN
  bnn_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk), .rst(rst), .clr(state != RUN), .en(state == RUN), .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      clr_cnt <= '0;
      bus.layer_go <= '0;
      bus.layer_latch <= '0;
      bus.cur_layer <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.cycle_count <= '0;
    end else begin
      bus.layer_latch <= '0;
      if (state inside {RUN, LATCH, CLEAR})
        bus.cycle_count <= CNT_W'(sat_inc(32'(bus.cycle_count), CNT_MAX));
      if (bus.abort) begin
        state <= IDLE;
        bus.layer_go <= '0;
        bus.busy <= 1'b0;
        bus.done <= 1'b0;
        bus.error <= 1'b0;
      end else
        case (state)
          IDLE: if (bus.start) begin
            state <= RUN;
            bus.cur_layer <= '0;
            bus.cycle_count <= '0;
            bus.layer_go <= NUM_LAYERS'(1);
            bus.busy <= 1'b1;
          end
          RUN: if (cur_done) begin
            state <= LATCH;
            bus.layer_latch <= NUM_LAYERS'(1) << bus.cur_layer;
          end else if (timeout) begin
            state <= ERROR;
            bus.layer_go <= '0;
            bus.busy <= 1'b0;
            bus.error <= 1'b1;
          end
          LATCH: begin
            state <= CLEAR;
            bus.layer_go <= '0;
            clr_cnt <= '0;
          end
          CLEAR: if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
            if (bus.cur_layer == LW'(NUM_LAYERS - 1)) begin
              state <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state <= RUN;
              bus.cur_layer <= bus.cur_layer + 1'b1;
              bus.layer_go <= NUM_LAYERS'(1) << (bus.cur_layer + 1'b1);
            end
          end else clr_cnt <= clr_cnt + 1'b1;
          DONE, ERROR: if (bus.result_ack) begin
            state <= IDLE;
            bus.done <= 1'b0;
            bus.error <= 1'b0;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// tb_bnn_layer_scheduler: randomized trace checks of three scheduler configurations against a per-cycle expected schedule
module tb_bnn_layer_scheduler;
  typedef struct packed {
    logic [1:0] go, latch, cur;
    logic busy, done, error;
    logic [15:0] cnt;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, result_ack = 1'b0;
  logic [1:0] stray = 2'b00;
  int need[2] = '{5, 7};
  int ca[2], cb[2], cc[2];
  int cmp = 0, fails = 0;
  always #5 clk = ~clk;
  bnn_layer_scheduler_if #(.NUM_LAYERS(2), .CNT_W(16)) ia();
  bnn_layer_scheduler_if #(.NUM_LAYERS(2), .CNT_W(16)) ib();
  bnn_layer_scheduler_if #(.NUM_LAYERS(2), .CNT_W(4)) ic();
  bnn_layer_scheduler #(.NUM_LAYERS(2), .CLEAR_CYCLES(1), .CNT_W(16), .TIMEOUT_CYCLES(8))
    da (.clk(clk), .rst(rst), .bus(ia));
  bnn_layer_scheduler #(.NUM_LAYERS(2), .CLEAR_CYCLES(3), .CNT_W(16), .TIMEOUT_CYCLES(64))
    db (.clk(clk), .rst(rst), .bus(ib));
  bnn_layer_scheduler #(.NUM_LAYERS(2), .CLEAR_CYCLES(1), .CNT_W(4), .TIMEOUT_CYCLES(64))
    dc (.clk(clk), .rst(rst), .bus(ic));
  assign {ia.start, ib.start, ic.start} = {3{start}};
  assign {ia.abort, ib.abort, ic.abort} = {3{abort}};
  assign {ia.result_ack, ib.result_ack, ic.result_ack} = {3{result_ack}};
  // Layer model: done rises on the need-th cycle with go high, clears when go drops.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      ca[i] <= ia.layer_go[i] ? ca[i] + 1 : 0;
      cb[i] <= ib.layer_go[i] ? cb[i] + 1 : 0;
      cc[i] <= ic.layer_go[i] ? cc[i] + 1 : 0;
    end
  always_comb
    for (int i = 0; i < 2; i++) begin
      ia.layer_done[i] = (ia.layer_go[i] && ca[i] >= need[i] - 1) || stray[i];
      ib.layer_done[i] = (ib.layer_go[i] && cb[i] >= need[i] - 1) || stray[i];
      ic.layer_done[i] = (ic.layer_go[i] && cc[i] >= need[i] - 1) || stray[i];
    end

  function automatic obs_t mk(input int go, latch, cur, busy, done, err, cnt);
    obs_t o;
    o.go = 2'(go); o.latch = 2'(latch); o.cur = 2'(cur);
    o.busy = 1'(busy); o.done = 1'(done); o.error = 1'(err); o.cnt = 16'(cnt);
    return o;
  endfunction

  function automatic obs_t get(input int k);
    obs_t o;
    case (k)
      0: o = mk(int'(ia.layer_go), int'(ia.layer_latch), int'(ia.cur_layer), int'(ia.busy), int'(ia.done), int'(ia.error), int'(ia.cycle_count));
      1: o = mk(int'(ib.layer_go), int'(ib.layer_latch), int'(ib.cur_layer), int'(ib.busy), int'(ib.done), int'(ib.error), int'(ib.cycle_count));
      default: o = mk(int'(ic.layer_go), int'(ic.layer_latch), int'(ic.cur_layer), int'(ic.busy), int'(ic.done), int'(ic.error), int'(ic.cycle_count));
    endcase
    return o;
  endfunction

  task automatic go_idle();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Expected schedule: per layer, n RUN cycles, one LATCH cycle, clr CLEAR cycles; count = cycles elapsed, saturated.
  task automatic run_check(input int k, input int clr, input int w, input int n0, input int n1, input bit fresh, input string name);
    obs_t q[$];
    obs_t o, e;
    int n[2];
    int sat = (1 << w) - 1;
    if (fresh) go_idle();
    need[0] = n0; need[1] = n1;
    n[0] = n0; n[1] = stray[1] ? 1 : n1;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r <= n[i]; r++) q.push_back(mk(1 << i, r == n[i] ? 1 << i : 0, i, 1, 0, 0, 0));
      for (int c = 0; c < clr; c++) q.push_back(mk(0, 0, i, 1, 0, 0, 0));
    end
    foreach (q[j]) q[j].cnt = 16'(j < sat ? j : sat);
    e = mk(0, 0, 1, 0, 1, 0, q.size() < sat ? q.size() : sat);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    foreach (q[j]) begin
      o = get(k); cmp++;
      if (o !== q[j]) begin fails++; $display("FAIL %s cyc%0d got %h exp %h", name, j, o, q[j]); end
      @(negedge clk);
    end
    o = get(k); cmp++;
    if (o !== e) begin fails++; $display("FAIL %s done got %h exp %h", name, o, e); end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    o = get(k); cmp++;
    if (o !== e) begin fails++; $display("FAIL %s start_in_done got %h exp %h", name, o, e); end
    result_ack = 1'b1;
    @(negedge clk) result_ack = 1'b0;
    o = get(k); cmp++;
    if ({o.go, o.latch, o.busy, o.done, o.error, o.cnt} !== {4'b0, 3'b0, e.cnt})
      begin fails++; $display("FAIL %s ack_idle got %h exp cnt %h idle", name, o, e.cnt); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cmp++;
      if (get(k) !== obs_t'(0)) begin fails++; $display("FAIL reset inst%0d got %h exp 0", k, get(k)); end
    end
  endtask

  task automatic test_nominal();
    run_check(0, 1, 16, 5, 7, 1, "nominal");
  endtask

  task automatic test_gap();
    run_check(1, 3, 16, 5, 7, 1, "gap3");
  endtask

  task automatic test_stray();
    stray = 2'b10;
    run_check(0, 1, 16, 5, 7, 1, "stray");
    stray = 2'b00;
  endtask

  task automatic test_saturation();
    run_check(2, 1, 4, 20, int'($urandom_range(1, 5)), 1, "saturate");
  endtask

  task automatic test_back_to_back();
    run_check(0, 1, 16, int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), 1, "b2b_first");
    run_check(0, 1, 16, int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int k = int'($urandom_range(0, 2));
      int mx = k == 0 ? 7 : 12;
      run_check(k, k == 1 ? 3 : 1, k == 2 ? 4 : 16, int'($urandom_range(1, mx)), int'($urandom_range(1, mx)), 1, $sformatf("rand%0d_inst%0d", it, k));
    end
  endtask

  task automatic test_abort();
    obs_t o;
    int n0 = int'($urandom_range(2, 7));
    go_idle();
    need[0] = n0; need[1] = 7;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (n0 - 1) @(negedge clk);
    cmp++;
    if (ia.layer_done[0] !== 1'b1) begin fails++; $display("FAIL abort_align done0 got %b exp 1", ia.layer_done[0]); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    for (int r = 0; r < 4; r++) begin
      o = get(0); cmp++;
      if ({o.go, o.latch, o.busy, o.done, o.error, o.cnt} !== {4'b0, 3'b0, 16'(n0)})
        begin fails++; $display("FAIL abort_idle t%0d got %h exp cnt %0d idle", r, o, n0); end
      @(negedge clk);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    o = get(0); cmp++;
    if ({o.go, o.busy} !== 3'b0) begin fails++; $display("FAIL abort_vs_start got %h exp go 0 busy 0", o); end
  endtask

  task automatic test_async_reset();
    go_idle();
    need[0] = 6; need[1] = 6;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      cmp++;
      if (get(k) !== obs_t'(0)) begin fails++; $display("FAIL async_rst inst%0d got %h exp 0", k, get(k)); end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_watchdog();
    obs_t o, e;
    int n0 = int'($urandom_range(1, 6));
    go_idle();
    need[0] = n0; need[1] = 1000;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (n0 + 10) @(negedge clk);
`ifdef BNN_SCHED_WATCHDOG_EN
    e = mk(0, 0, 1, 0, 0, 1, n0 + 10);
`else
    e = mk(2, 0, 1, 1, 0, 0, n0 + 10);
`endif
    o = get(0); cmp++;
    if (o !== e) begin fails++; $display("FAIL watchdog got %h exp %h", o, e); end
    result_ack = 1'b1;
    @(negedge clk) result_ack = 1'b0;
    o = get(0); cmp++;
`ifdef BNN_SCHED_WATCHDOG_EN
    if ({o.go, o.busy, o.error} !== 4'b0) begin fails++; $display("FAIL watchdog_ack got %h exp idle", o); end
`else
    if ({o.go, o.busy, o.error} !== 4'b1010) begin fails++; $display("FAIL watchdog_ack got %h exp still running", o); end
`endif
  endtask

  initial begin
    #12 test_reset();
    @(negedge clk) rst = 1'b0;
    test_nominal();
    test_gap();
    test_stray();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    test_watchdog();
    go_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/bnn_layer_scheduler.md
Name: bnn_layer_scheduler

Overview:
- Sequences a chain of BNN conv+maxpool layers: raises each layer's level-sensitive go input, waits for its done, pulses a capture strobe into the inter-layer buffer, then drops go so the layer clears itself.
- Sits between the top-level image/command controller (start/ack) and the NUM_LAYERS layer instances.
- Also runs a cycle counter for inference profiling.

Parameters:
- NUM_LAYERS, 2, number of sequenced layers (>=1).
- CLEAR_CYCLES, 1, cycles go is held low between layers (>=1) so a layer's synchronous clear completes.
- CNT_W, 16, width of cycle_count.
- TIMEOUT_CYCLES, 4096, per-layer watchdog limit (used only with the watchdog macro).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request an inference; sampled only in IDLE.
- abort  in  1  cancel; returns to IDLE from any state.
- result_ack  in  1  consumer has read results; releases DONE/ERROR.
- layer_done  in  NUM_LAYERS  per-layer data_out_ready (level).
- layer_go  out  NUM_LAYERS  per-layer data_in_ready (level, at most one bit high).
- layer_latch  out  NUM_LAYERS  one-cycle capture strobe for layer i's output buffer.
- cur_layer  out  $clog2(NUM_LAYERS)+1  index of the active layer.
- busy  out  1  high in RUN/LATCH/CLEAR.
- done  out  1  high in DONE.
- error  out  1  high in ERROR (watchdog build only, else 0).
- cycle_count  out  CNT_W  cycles spent in RUN/LATCH/CLEAR for the last or current inference.

Behaviour:
- All outputs are registered (Moore). On reset: state=IDLE, layer_go=0, layer_latch=0, cur_layer=0, busy=0, done=0, error=0, cycle_count=0.
- IDLE:
  - If start=1, go to RUN with cur_layer=0 and cycle_count cleared to 0.
  - layer_go[0] is high in the first cycle after start is sampled.
- RUN:
  - layer_go[cur_layer]=1.
  - If layer_done[cur_layer]=1, go to LATCH.
  - layer_done bits of non-current layers are ignored.
- LATCH (1 cycle):
  - layer_go is still high, so the layer's output stays stable.
  - layer_latch[cur_layer]=1.
  - Next state is CLEAR.
- CLEAR (CLEAR_CYCLES cycles): layer_go=0 and a local counter runs. At the end:
  - if cur_layer==NUM_LAYERS-1, go to DONE;
  - otherwise cur_layer+1 and go to RUN.
- DONE:
  - done=1, cur_layer holds the last index, cycle_count is frozen.
  - result_ack=1 goes to IDLE.
  - start is ignored in DONE.
- cycle_count:
  - Increments once per cycle in RUN, LATCH and CLEAR.
  - Saturates at all-ones with no wrap.
  - Holds its value in IDLE and DONE until the next accepted start.
- Abort:
  - abort=1 in RUN/LATCH/CLEAR/DONE/ERROR goes to IDLE on the next edge, with layer_go=0 and no latch strobe.
  - abort takes priority over layer_done, the CLEAR expiry and result_ack in the same cycle.
  - abort in IDLE has no effect, and takes priority over a simultaneous start.
- Asynchronous rst mid-operation: all outputs go to their reset values immediately. Layers see go low and clear themselves.
- layer_done held high across the CLEAR to RUN boundary is not a hazard, because the next layer's done bit is the one sampled.
- Invariant: $onehot0(layer_go) and $onehot0(layer_latch) hold at all times, and layer_latch is never high while layer_go of the same index is low.

Optional Feature:
- Macro BNN_SCHED_WATCHDOG_EN.
- Defined:
  - A per-layer counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without layer_done, the block goes to ERROR: error=1, layer_go=0, busy=0, cur_layer holds the failing layer.
  - ERROR exits to IDLE on result_ack or abort.
- Undefined: no counter logic, error is tied to 0, ERROR is unreachable and RUN waits indefinitely.

Decomposition:
- Package bnn_sched_pkg:
  - state enum sched_state_t {IDLE, RUN, LATCH, CLEAR, DONE, ERROR}.
  - Default constants for CLEAR_CYCLES, CNT_W and TIMEOUT_CYCLES.
  - Saturating-increment function used by both counters.
- Sub-module bnn_sched_watchdog (counter plus timeout compare, clear/enable inputs, expired output), instantiated only under BNN_SCHED_WATCHDOG_EN.

Test Plan (NUM_LAYERS=2, CLEAR_CYCLES=1; layer model raises done after N go-high cycles and clears when go drops):
- Nominal: start pulse, layer0 done on its 5th RUN cycle, layer1 on its 7th.
  - Expect layer_latch pulses 01 then 10, each with the matching go high.
  - Expect done=1 with cycle_count=16; result_ack returns to IDLE.
- Gap: check layer_go=00 for exactly 1 cycle between layer_go=01 and 10. Repeat with CLEAR_CYCLES=3 and expect a 3-cycle gap and cycle_count=20.
- Abort: abort asserted simultaneously with layer_done[0]. Expect no layer_latch, IDLE next edge, layer_go=00, busy=0, cycle_count frozen.
- Stray done: layer_done[1] high throughout layer0's RUN. Expect it ignored, so layer0 still takes 5 RUN cycles.
- Saturation: CNT_W=4 with layer0 taking 20 cycles. Expect cycle_count=15 in DONE; start during DONE is ignored.
- Watchdog (BNN_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=8): layer1 never completes.
  - Expect error=1 after 8 RUN cycles, cur_layer=1, layer_go=00; result_ack returns to IDLE.
  - Without the macro, expect error=0 and busy remaining 1.
